// File: rtl/apu_pkg.sv
// Shared APU definitions: length-counter load table and register offsets.
// Imported by the triangle front end and the reusable length counter.
package apu_pkg;

    localparam logic [1:0] REG_LINEAR   = 2'd0;
    localparam logic [1:0] REG_TIMER_LO = 2'd2;
    localparam logic [1:0] REG_TIMER_HI = 2'd3;

    localparam logic [7:0] LENGTH_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    function automatic logic [7:0] length_lookup(input logic [4:0] idx);
        return LENGTH_TABLE[idx];
    endfunction

endpackage

// File: rtl/apu_length_counter.sv
// APU length counter: table load, half-frame decrement, halt and enable.
// Shared by the triangle, pulse and noise channels.
module apu_length_counter
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_en,
    input  logic       halt_i,
    input  logic       load_i,
    input  logic [4:0] load_idx_i,
    input  logic       enable_i,
    input  logic       half_frame_i,
    output logic       active_o
);

    logic [7:0] len_q;
    logic [7:0] len_d;

    // Disable beats load, and load beats a same-cycle decrement.
    always_comb begin
        len_d = len_q;
        if (!enable_i) begin
            len_d = '0;
        end else if (load_i) begin
            len_d = length_lookup(load_idx_i);
        end else if (half_frame_i && !halt_i && (len_q != 8'd0)) begin
            len_d = len_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q <= '0;
        end else if (cpu_en) begin
            len_q <= len_d;
        end
    end

    assign active_o = (len_q != 8'd0);

endmodule

// File: rtl/tri_channel_ctrl.sv
// Triangle channel control: register decode, period timer, linear counter.
// Define TRI_ULTRASONIC_MUTE_EN to freeze the sequencer for periods below 2.
module tri_channel_ctrl
    import apu_pkg::*;
#(
    parameter int TIMER_W = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_en,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    input  logic       channel_en,
    input  logic       quarter_frame,
    input  logic       half_frame,
    output logic       next_step,
    output logic       length_active
);

    logic [TIMER_W-1:0] period_q, period_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [6:0]         linear_q, linear_d;
    logic [6:0]         reload_val_q, reload_val_d;
    logic               ctrl_q, ctrl_d;
    logic               reload_flag_q, reload_flag_d;
    logic               next_step_q, next_step_d;
    logic               len_active;
    logic               timer_evt;
    logic               hi_wr;
    logic               gate;

    assign hi_wr     = reg_we && (reg_addr == REG_TIMER_HI);
    assign timer_evt = (timer_q == '0);

`ifdef TRI_ULTRASONIC_MUTE_EN
    assign gate = (period_q >= TIMER_W'(2));
`else
    assign gate = 1'b1;
`endif

    always_comb begin
        period_d      = period_q;
        reload_val_d  = reload_val_q;
        ctrl_d        = ctrl_q;
        linear_d      = linear_q;
        reload_flag_d = reload_flag_q;
        timer_d       = timer_evt ? period_q : (timer_q - TIMER_W'(1));
        next_step_d   = timer_evt && (linear_q != 7'd0) && len_active && gate;

        // Quarter tick sees the pre-write flag; a $400B write re-arms it after.
        if (quarter_frame) begin
            if (reload_flag_q) begin
                linear_d = reload_val_q;
            end else if (linear_q != 7'd0) begin
                linear_d = linear_q - 7'd1;
            end
            if (!ctrl_q) begin
                reload_flag_d = 1'b0;
            end
        end

        if (reg_we) begin
            unique case (reg_addr)
                REG_LINEAR: begin
                    ctrl_d       = reg_wdata[7];
                    reload_val_d = reg_wdata[6:0];
                end
                REG_TIMER_LO: period_d[7:0] = reg_wdata;
                REG_TIMER_HI: begin
                    period_d[TIMER_W-1:8] = reg_wdata[TIMER_W-9:0];
                    reload_flag_d         = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q      <= '0;
            timer_q       <= '0;
            linear_q      <= '0;
            reload_val_q  <= '0;
            ctrl_q        <= 1'b0;
            reload_flag_q <= 1'b0;
            next_step_q   <= 1'b0;
        end else if (cpu_en) begin
            period_q      <= period_d;
            timer_q       <= timer_d;
            linear_q      <= linear_d;
            reload_val_q  <= reload_val_d;
            ctrl_q        <= ctrl_d;
            reload_flag_q <= reload_flag_d;
            next_step_q   <= next_step_d;
        end
    end

    apu_length_counter u_len (
        .clk          (clk),
        .reset        (reset),
        .cpu_en       (cpu_en),
        .halt_i       (ctrl_q),
        .load_i       (hi_wr),
        .load_idx_i   (reg_wdata[7:3]),
        .enable_i     (channel_en),
        .half_frame_i (half_frame),
        .active_o     (len_active)
    );

    assign next_step     = next_step_q;
    assign length_active = len_active;

endmodule
